pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised next-generation hazard/stall controller for the 5-stage core (pc, if_id, id_ex, ex_me, me_wb).
- Adds the following over the current controller:
  - bus wait-state handling for the fetch and memory ports
  - a registered pending-redirect FSM, so a branch or trap taken during an outstanding fetch is not lost
  - trap flush
  - optional mem-stage load-use interlock
  - x0 hazard exclusion
  - saturating stall and flush performance counters
- Sits beside the pipeline registers and drives their 2-bit stall controls. Encodings are the `STALL_NEXT`, `STALL_KEEP` and `STALL_ZERO` macros from defines.v.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of each performance counter.
- MEM_FWD, 1. 1 = mem-stage load data is forwardable. 0 = a mem-stage load also causes a load-use stall.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- ex_mem_rena  in  1  EX instruction is a load
- ex_csr_rena  in  1  EX instruction reads a CSR
- ex_rd_waddr  in  REG_AW  EX destination register
- me_mem_rena  in  1  MEM instruction is a load
- me_rd_waddr  in  REG_AW  MEM destination register
- id_rs1_rena, id_rs2_rena  in  1 each  ID source-register read enables
- id_rs1_addr, id_rs2_addr  in  REG_AW each  ID source-register addresses
- transfer  in  1  taken branch/jump resolved in EX
- trap_req  in  1  exception/interrupt redirect
- exe_stall_req  in  1  multi-cycle mul/div busy
- if_req_valid, if_ready  in  1 each  fetch request outstanding / fetch response accepted
- mem_req_valid, mem_ready  in  1 each  data request outstanding / data response accepted
- pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall  out  2 each  stage controls
- redirect_fire  out  1  one-cycle pulse telling the PC unit to load its redirect target
- stall_cnt  out  CNT_W  number of cycles in which pc_stall != NEXT
- flush_cnt  out  CNT_W  number of redirect_fire pulses

Behaviour:
Derived signals:
- hz(a): (ex_mem_rena | ex_csr_rena) & (a == ex_rd_waddr); when MEM_FWD = 0, additionally OR me_mem_rena & (a == me_rd_waddr).
- lu: (id_rs1_rena & rs1 != 0 & hz(rs1)) | (id_rs2_rena & rs2 != 0 & hz(rs2)). Register x0 never causes a hazard.
- fbusy = if_req_valid & ~if_ready.
- mwait = mem_req_valid & ~mem_ready.

Control tuples below are listed as (pc, if_id, id_ex, ex_me, me_wb).

FSM states RUN and REDIR_WAIT; the state register and counters are the only flops. Stall outputs and redirect_fire are combinational from state and inputs.

RUN, first match wins:
1. trap_req & ~fbusy: (NEXT, ZERO, ZERO, ZERO, NEXT); redirect_fire = 1.
2. trap_req & fbusy: (KEEP, ZERO, ZERO, ZERO, NEXT); go to REDIR_WAIT.
3. mwait: (KEEP, KEEP, KEEP, KEEP, ZERO).
4. transfer & ~fbusy: (NEXT, ZERO, ZERO, NEXT, NEXT); redirect_fire = 1.
5. transfer & fbusy: (KEEP, ZERO, ZERO, NEXT, NEXT); go to REDIR_WAIT.
6. exe_stall_req: (KEEP, KEEP, KEEP, ZERO, NEXT).
7. lu: (KEEP, KEEP, ZERO, NEXT, NEXT).
8. Otherwise all NEXT.

REDIR_WAIT, first match wins:
1. trap_req: as RUN row 1 if if_ready, otherwise as RUN row 2. On if_ready, fire and return to RUN.
2. mwait: (KEEP, KEEP, KEEP, KEEP, ZERO); hold state. The pending redirect stays pending.
3. if_ready: (NEXT, ZERO, ZERO, NEXT, NEXT); redirect_fire = 1; return to RUN.
4. Otherwise: (KEEP, ZERO, ZERO, NEXT, NEXT); hold state.

Boundary rules:
- The discarded fetch response is squashed by the ZERO on if_id.
- redirect_fire is asserted for exactly one cycle per redirect. It never fires in two consecutive cycles for the same transfer, because EX is zeroed.

Counters:
- Both increment by 1 on their qualifying cycle and saturate at 2^CNT_W - 1 (no wrap).
- Both hold during reset.

Reset (synchronous):
- Next state RUN; both counters cleared to 0.
- While reset is high, outputs are forced to (KEEP, ZERO, ZERO, ZERO, ZERO) with redirect_fire = 0.
- Reset mid-REDIR_WAIT drops the pending redirect.

Test Plan:
1. Load-use: ex_mem_rena = 1, ex_rd_waddr = 5, id_rs1_addr = 5, rs1_rena = 1 -> (KEEP, KEEP, ZERO, NEXT, NEXT); stall_cnt goes 0 -> 1. Repeat with addr 0 -> all NEXT, stall_cnt unchanged.
2. MEM_FWD = 0 build: me_mem_rena = 1, me_rd_waddr = 7, id_rs2_addr = 7 -> load-use stall. MEM_FWD = 1 build, same stimulus -> all NEXT.
3. transfer with if_req_valid = 1, if_ready = 0 for 3 cycles, then if_ready = 1 -> 3 cycles of (KEEP, ZERO, ZERO, NEXT, NEXT), then one redirect_fire with pc NEXT, state back to RUN, flush_cnt = 1.
4. mwait and transfer together -> all-KEEP/me_wb ZERO until mem_ready, then redirect_fire in the following cycle.
5. trap_req while in REDIR_WAIT with if_ready = 1 -> ex_me ZERO, redirect_fire = 1, single pulse.
6. CNT_W = 3, 9 continuous stall cycles -> stall_cnt saturates at 7. Reset asserted mid-REDIR_WAIT -> counters 0, no redirect_fire after reset deasserts.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: hazard/stall controller for the 5-stage core, with     |
// | fetch/memory wait states, pending-redirect FSM and saturating counters.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int MEM_FWD = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_rena,
    input  logic              ex_csr_rena,
    input  logic [REG_AW-1:0] ex_rd_waddr,
    input  logic              me_mem_rena,
    input  logic [REG_AW-1:0] me_rd_waddr,
    input  logic              id_rs1_rena,
    input  logic              id_rs2_rena,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              transfer,
    input  logic              trap_req,
    input  logic              exe_stall_req,
    input  logic              if_req_valid,
    input  logic              if_ready,
    input  logic              mem_req_valid,
    input  logic              mem_ready,
    output logic [1:0]        pc_stall,
    output logic [1:0]        if_id_stall,
    output logic [1:0]        id_ex_stall,
    output logic [1:0]        ex_me_stall,
    output logic [1:0]        me_wb_stall,
    output logic              redirect_fire,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] c_NEXT = 2'b00;
    localparam logic [1:0] c_KEEP = 2'b01;
    localparam logic [1:0] c_ZERO = 2'b10;

    localparam logic [0:0]       c_RUN        = 1'b0;
    localparam logic [0:0]       c_REDIR_WAIT = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [9:0]       w_ctl;
    logic             w_fire;
    logic             w_ex_ld;
    logic             w_me_ld;
    logic             w_rs1_hz;
    logic             w_rs2_hz;
    logic             w_lu;
    logic             w_fbusy;
    logic             w_mwait;

    // A mem-stage load only interlocks when its data cannot be forwarded.
    assign w_ex_ld  = ex_mem_rena | ex_csr_rena;
    assign w_me_ld  = (MEM_FWD == 0) && me_mem_rena;
    assign w_rs1_hz = id_rs1_rena && (id_rs1_addr != '0) &&
                      ((w_ex_ld && (id_rs1_addr == ex_rd_waddr)) ||
                       (w_me_ld && (id_rs1_addr == me_rd_waddr)));
    assign w_rs2_hz = id_rs2_rena && (id_rs2_addr != '0) &&
                      ((w_ex_ld && (id_rs2_addr == ex_rd_waddr)) ||
                       (w_me_ld && (id_rs2_addr == me_rd_waddr)));
    assign w_lu     = w_rs1_hz | w_rs2_hz;
    assign w_fbusy  = if_req_valid & ~if_ready;
    assign w_mwait  = mem_req_valid & ~mem_ready;

    always_comb begin
        w_ctl       = {c_NEXT, c_NEXT, c_NEXT, c_NEXT, c_NEXT};
        w_fire      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_RUN: begin
                if (trap_req && !w_fbusy) begin
                    w_ctl  = {c_NEXT, c_ZERO, c_ZERO, c_ZERO, c_NEXT};
                    w_fire = 1'b1;
                end else if (trap_req) begin
                    w_ctl       = {c_KEEP, c_ZERO, c_ZERO, c_ZERO, c_NEXT};
                    w_state_nxt = c_REDIR_WAIT;
                end else if (w_mwait) begin
                    w_ctl = {c_KEEP, c_KEEP, c_KEEP, c_KEEP, c_ZERO};
                end else if (transfer && !w_fbusy) begin
                    w_ctl  = {c_NEXT, c_ZERO, c_ZERO, c_NEXT, c_NEXT};
                    w_fire = 1'b1;
                end else if (transfer) begin
                    w_ctl       = {c_KEEP, c_ZERO, c_ZERO, c_NEXT, c_NEXT};
                    w_state_nxt = c_REDIR_WAIT;
                end else if (exe_stall_req) begin
                    w_ctl = {c_KEEP, c_KEEP, c_KEEP, c_ZERO, c_NEXT};
                end else if (w_lu) begin
                    w_ctl = {c_KEEP, c_KEEP, c_ZERO, c_NEXT, c_NEXT};
                end
            end
            default: begin
                // Redirect pending: the outstanding fetch must retire before the PC reloads.
                if (trap_req) begin
                    if (if_ready) begin
                        w_ctl       = {c_NEXT, c_ZERO, c_ZERO, c_ZERO, c_NEXT};
                        w_fire      = 1'b1;
                        w_state_nxt = c_RUN;
                    end else begin
                        w_ctl = {c_KEEP, c_ZERO, c_ZERO, c_ZERO, c_NEXT};
                    end
                end else if (w_mwait) begin
                    w_ctl = {c_KEEP, c_KEEP, c_KEEP, c_KEEP, c_ZERO};
                end else if (if_ready) begin
                    w_ctl       = {c_NEXT, c_ZERO, c_ZERO, c_NEXT, c_NEXT};
                    w_fire      = 1'b1;
                    w_state_nxt = c_RUN;
                end else begin
                    w_ctl = {c_KEEP, c_ZERO, c_ZERO, c_NEXT, c_NEXT};
                end
            end
        endcase
        if (reset) begin
            w_ctl       = {c_KEEP, c_ZERO, c_ZERO, c_ZERO, c_ZERO};
            w_fire      = 1'b0;
            w_state_nxt = c_RUN;
        end
    end

    assign {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall} = w_ctl;
    assign redirect_fire = w_fire;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((pc_stall != c_NEXT) && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_fire && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] Z = 2'b10;

    localparam logic [9:0] ALLN      = {N, N, N, N, N};
    localparam logic [9:0] RSTV      = {K, Z, Z, Z, Z};
    localparam logic [9:0] LU        = {K, K, Z, N, N};
    localparam logic [9:0] EXS       = {K, K, K, Z, N};
    localparam logic [9:0] MW        = {K, K, K, K, Z};
    localparam logic [9:0] TR_FIRE   = {N, Z, Z, N, N};
    localparam logic [9:0] TR_WAIT   = {K, Z, Z, N, N};
    localparam logic [9:0] TRAP_FIRE = {N, Z, Z, Z, N};

    logic       clock = 1'b0;
    logic       reset;
    logic       ex_mem_rena, ex_csr_rena, me_mem_rena;
    logic [4:0] ex_rd_waddr, me_rd_waddr, id_rs1_addr, id_rs2_addr;
    logic       id_rs1_rena, id_rs2_rena, transfer, trap_req, exe_stall_req;
    logic       if_req_valid, if_ready, mem_req_valid, mem_ready;

    logic [9:0]  m_ctl, f_ctl, c_ctl;
    logic        m_fire, f_fire, c_fire;
    logic [31:0] m_stall, m_flush, f_stall, f_flush;
    logic [2:0]  c_stall, c_flush;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MEM_FWD(1)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_rena(ex_mem_rena), .ex_csr_rena(ex_csr_rena), .ex_rd_waddr(ex_rd_waddr),
        .me_mem_rena(me_mem_rena), .me_rd_waddr(me_rd_waddr),
        .id_rs1_rena(id_rs1_rena), .id_rs2_rena(id_rs2_rena),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .transfer(transfer), .trap_req(trap_req), .exe_stall_req(exe_stall_req),
        .if_req_valid(if_req_valid), .if_ready(if_ready),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .pc_stall(m_ctl[9:8]), .if_id_stall(m_ctl[7:6]), .id_ex_stall(m_ctl[5:4]),
        .ex_me_stall(m_ctl[3:2]), .me_wb_stall(m_ctl[1:0]),
        .redirect_fire(m_fire), .stall_cnt(m_stall), .flush_cnt(m_flush)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MEM_FWD(0)) dut_nofwd (
        .clock(clock), .reset(reset),
        .ex_mem_rena(ex_mem_rena), .ex_csr_rena(ex_csr_rena), .ex_rd_waddr(ex_rd_waddr),
        .me_mem_rena(me_mem_rena), .me_rd_waddr(me_rd_waddr),
        .id_rs1_rena(id_rs1_rena), .id_rs2_rena(id_rs2_rena),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .transfer(transfer), .trap_req(trap_req), .exe_stall_req(exe_stall_req),
        .if_req_valid(if_req_valid), .if_ready(if_ready),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .pc_stall(f_ctl[9:8]), .if_id_stall(f_ctl[7:6]), .id_ex_stall(f_ctl[5:4]),
        .ex_me_stall(f_ctl[3:2]), .me_wb_stall(f_ctl[1:0]),
        .redirect_fire(f_fire), .stall_cnt(f_stall), .flush_cnt(f_flush)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(3), .MEM_FWD(1)) dut_cnt3 (
        .clock(clock), .reset(reset),
        .ex_mem_rena(ex_mem_rena), .ex_csr_rena(ex_csr_rena), .ex_rd_waddr(ex_rd_waddr),
        .me_mem_rena(me_mem_rena), .me_rd_waddr(me_rd_waddr),
        .id_rs1_rena(id_rs1_rena), .id_rs2_rena(id_rs2_rena),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .transfer(transfer), .trap_req(trap_req), .exe_stall_req(exe_stall_req),
        .if_req_valid(if_req_valid), .if_ready(if_ready),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
        .pc_stall(c_ctl[9:8]), .if_id_stall(c_ctl[7:6]), .id_ex_stall(c_ctl[5:4]),
        .ex_me_stall(c_ctl[3:2]), .me_wb_stall(c_ctl[1:0]),
        .redirect_fire(c_fire), .stall_cnt(c_stall), .flush_cnt(c_flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ex_mem_rena = 0; ex_csr_rena = 0; ex_rd_waddr = 0;
        me_mem_rena = 0; me_rd_waddr = 0;
        id_rs1_rena = 0; id_rs2_rena = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        transfer = 0; trap_req = 0; exe_stall_req = 0;
        if_req_valid = 0; if_ready = 0; mem_req_valid = 0; mem_ready = 0;
    endtask

    // Advance one clock, then settle past the edge before driving/sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1;
        idle();
        #1;
        chk("reset_ctl", 32'(m_ctl), 32'(RSTV));
        chk("reset_fire", 32'(m_fire), 32'd0);
        tick();
        chk("reset_stall_cnt", m_stall, 32'd0);
        chk("reset_flush_cnt", m_flush, 32'd0);
        reset = 0;

        // load-use on rs1 against an EX load
        ex_mem_rena = 1; ex_rd_waddr = 5; id_rs1_rena = 1; id_rs1_addr = 5;
        #1;
        chk("lu_rs1_ctl", 32'(m_ctl), 32'(LU));
        tick();
        chk("lu_rs1_cnt", m_stall, 32'd1);

        // x0 never hazards
        ex_rd_waddr = 0; id_rs1_addr = 0;
        #1;
        chk("x0_ctl", 32'(m_ctl), 32'(ALLN));
        tick();
        chk("x0_cnt", m_stall, 32'd1);

        // CSR read in EX on rs2
        idle();
        ex_csr_rena = 1; ex_rd_waddr = 3; id_rs2_rena = 1; id_rs2_addr = 3;
        #1;
        chk("lu_csr_ctl", 32'(m_ctl), 32'(LU));
        tick();
        chk("lu_csr_cnt", m_stall, 32'd2);

        // mem-stage load: interlocks only without forwarding
        idle();
        me_mem_rena = 1; me_rd_waddr = 7; id_rs2_rena = 1; id_rs2_addr = 7;
        #1;
        chk("memld_fwd_ctl", 32'(m_ctl), 32'(ALLN));
        chk("memld_nofwd_ctl", 32'(f_ctl), 32'(LU));
        tick();
        chk("memld_fwd_cnt", m_stall, 32'd2);
        chk("memld_nofwd_cnt", f_stall, 32'd3);

        // nine continuous stall cycles saturate the 3-bit counter
        idle();
        ex_mem_rena = 1; ex_rd_waddr = 5; id_rs1_rena = 1; id_rs1_addr = 5;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_cnt3", 32'(c_stall), 32'd7);
        chk("sat_cnt32", m_stall, 32'd11);

        idle();
        exe_stall_req = 1;
        #1;
        chk("exe_stall_ctl", 32'(m_ctl), 32'(EXS));
        tick();

        // transfer during outstanding fetch: three wait cycles, then one redirect
        idle();
        transfer = 1; if_req_valid = 1;
        #1;
        chk("tr_wait0_ctl", 32'(m_ctl), 32'(TR_WAIT));
        chk("tr_wait0_fire", 32'(m_fire), 32'd0);
        tick();
        transfer = 0;
        #1;
        chk("tr_wait1_ctl", 32'(m_ctl), 32'(TR_WAIT));
        tick();
        chk("tr_wait2_ctl", 32'(m_ctl), 32'(TR_WAIT));
        chk("tr_wait2_fire", 32'(m_fire), 32'd0);
        tick();
        if_ready = 1;
        #1;
        chk("tr_fire_ctl", 32'(m_ctl), 32'(TR_FIRE));
        chk("tr_fire", 32'(m_fire), 32'd1);
        tick();
        chk("tr_flush_cnt", m_flush, 32'd1);
        chk("tr_stall_cnt", m_stall, 32'd15);
        idle();
        #1;
        chk("tr_back_run_ctl", 32'(m_ctl), 32'(ALLN));
        chk("tr_single_pulse", 32'(m_fire), 32'd0);
        tick();

        // data wait outranks transfer; redirect once mem_ready arrives
        mem_req_valid = 1; transfer = 1;
        #1;
        chk("mw_tr_ctl0", 32'(m_ctl), 32'(MW));
        chk("mw_tr_fire0", 32'(m_fire), 32'd0);
        tick();
        chk("mw_tr_ctl1", 32'(m_ctl), 32'(MW));
        tick();
        mem_ready = 1;
        #1;
        chk("mw_tr_release_fire", 32'(m_fire), 32'd1);
        chk("mw_tr_release_ctl", 32'(m_ctl), 32'(TR_FIRE));
        tick();
        chk("mw_tr_flush_cnt", m_flush, 32'd2);

        // trap arriving while a redirect is pending
        idle();
        transfer = 1; if_req_valid = 1;
        tick();
        transfer = 0; trap_req = 1; if_ready = 1;
        #1;
        chk("trap_redir_ctl", 32'(m_ctl), 32'(TRAP_FIRE));
        chk("trap_redir_fire", 32'(m_fire), 32'd1);
        tick();
        idle();
        #1;
        chk("trap_single_pulse", 32'(m_fire), 32'd0);
        chk("trap_flush_cnt", m_flush, 32'd3);
        tick();

        // data wait holds a pending redirect
        transfer = 1; if_req_valid = 1;
        tick();
        transfer = 0; if_ready = 1; mem_req_valid = 1;
        #1;
        chk("redir_mw_ctl", 32'(m_ctl), 32'(MW));
        chk("redir_mw_fire", 32'(m_fire), 32'd0);
        tick();
        mem_req_valid = 0;
        #1;
        chk("redir_mw_release", 32'(m_fire), 32'd1);
        tick();
        chk("redir_mw_cnts", m_stall, 32'd20);

        // trap in RUN beats a data wait
        idle();
        trap_req = 1; mem_req_valid = 1;
        #1;
        chk("trap_run_ctl", 32'(m_ctl), 32'(TRAP_FIRE));
        tick();
        chk("trap_run_flush", m_flush, 32'd5);

        // reset while a redirect is pending drops it
        idle();
        transfer = 1; if_req_valid = 1;
        tick();
        transfer = 0; reset = 1; if_ready = 1;
        #1;
        chk("rst_redir_ctl", 32'(m_ctl), 32'(RSTV));
        chk("rst_redir_fire", 32'(m_fire), 32'd0);
        tick();
        reset = 0;
        #1;
        chk("post_rst_no_fire", 32'(m_fire), 32'd0);
        chk("post_rst_ctl", 32'(m_ctl), 32'(ALLN));
        chk("post_rst_stall", m_stall, 32'd0);
        chk("post_rst_flush", m_flush, 32'd0);
        chk("post_rst_cnt3", 32'(c_stall), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
